mul_wb_unit: RTL
================

MUL_WB_UNIT -- requirements
Module: mul_wb_unit

Interface
REQ-001 Parameter W, default 8, datapath width; the value written to the register file and the operand width.
REQ-002 Parameter D, default 3, register-file pointer width.
REQ-003 Parameter REG_M, default 3'b100, register that receives the product high byte.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset. All state SHALL update on posedge CLK, and reset SHALL take effect immediately when RESET_N falls.
REQ-005 CLK  input  1  system clock.
REQ-006 RESET_N  input  1  asynchronous active-low reset.
REQ-007 start  input  1  request to multiply; sampled only in IDLE.
REQ-008 dest  input  D  destination register for the product low byte; latched with start.
REQ-009 opA  input  W  multiplicand; comes from register-file read port A; latched with start.
REQ-010 opB  input  W  multiplier; comes from register-file read port B; latched with start.
REQ-011 busy  output  1  high in every state except IDLE; the core stalls issue while busy is high.
REQ-012 done  output  1  one-cycle pulse during WB_HI.
REQ-013 rf_write_en  output  1  drives the register-file write enable.
REQ-014 rf_waddr  output  D  drives the register-file write address.
REQ-015 rf_data_in  output  W  drives the register-file write data.

Function
REQ-016 The FSM SHALL have four states: IDLE, MULT, WB_LO and WB_HI. All outputs SHALL be Moore-decoded from state and datapath registers.
REQ-017 Transitions:
- IDLE -> MULT when start=1 at an edge; dest, opA and opB are latched at that edge, the product accumulator is cleared and the iteration counter is cleared.
- MULT -> WB_LO after exactly W MULT cycles.
- WB_LO -> WB_HI unconditionally.
- WB_HI -> IDLE unconditionally.
REQ-018 The multiply SHALL be an unsigned 2W-bit product computed by shift-add, one multiplier bit per MULT cycle, LSB first. Intermediate sums SHALL keep the carry, so there is no truncation before 2W bits.
REQ-019 Latency: start sampled at edge E0 -> low-byte write committed at edge E(W+1) -> high-byte write committed at E(W+2) -> IDLE from E(W+2). The next start can be accepted at E(W+3).
REQ-020 In WB_LO the outputs SHALL be: rf_write_en=1, rf_waddr=latched dest, rf_data_in=product[W-1:0].
REQ-021 In WB_HI the outputs SHALL be: rf_write_en=1, rf_waddr=REG_M, rf_data_in=product[2W-1:W], done=1.
REQ-022 In IDLE and MULT the outputs SHALL be: rf_write_en=0, rf_waddr=0, rf_data_in=0.
REQ-023 start asserted while busy=1 SHALL be ignored, with no queuing and no change to the latched operands.
REQ-024 Changes on opA, opB or dest after the start edge SHALL NOT affect the result.
REQ-025 If dest==REG_M, both writes SHALL occur in order, so REG_M finally holds the high byte.
REQ-026 dest==0 SHALL be written normally; this block does not blank address 0.
REQ-027 An opA or opB of 0 SHALL still take the full W+2 cycles and SHALL write 0 to both registers.

Reset
REQ-028 While RESET_N=0: state=IDLE, counter=0, accumulator and latched operands=0. Outputs busy=0, done=0, rf_write_en=0, rf_waddr=0, rf_data_in=0.
REQ-029 A reset asserted mid-MULT, mid-WB_LO or mid-WB_HI SHALL abort the operation. No further rf_write_en pulse SHALL follow, although writes already committed stand.
REQ-030 start presented in the same cycle that RESET_N deasserts SHALL be accepted only if RESET_N is high at that edge.

Verification
REQ-031 Basic multiply: opA=3, opB=5, dest=2, start for one cycle.
- Expect busy for W+2 cycles.
- E9: write r2=0x0F.
- E10: write r4=0x00, with done high in the WB_HI cycle.
REQ-032 Maximum operands: opA=0xFF, opB=0xFF, dest=1. Expect r1=0x01 and r4=0xFE.
REQ-033 Start while busy: opA=2, opB=3, dest=5, then at cycle 3 start again with opA=7. Expect only r5=0x06 and r4=0x00, and exactly two write pulses in total.
REQ-034 Reset mid-operation: RESET_N low during MULT cycle 4. Expect busy=0 and rf_write_en=0 immediately, with no writes afterwards. A new 4*4 after release yields dest=0x10.
REQ-035 dest equals REG_M: opA=0x10, opB=0x20, dest=4. Expect write r4=0x00, then r4=0x02; final r4=0x02.
REQ-036 Operands change after start: opB driven to 0 at E1. Expect the result to still use the latched opB.

Source files
------------

// File: rtl/mul_wb_unit.sv
// Sequential shift-add multiplier with two-beat register-file write-back.
// The low half of the product goes to the latched destination register.
// The high half then goes to the fixed register REG_M.
//
// Ports:
//   CLK, RESET_N    clock and asynchronous active-low reset
//   start           multiply request, sampled only while idle
//   dest, opA, opB  destination pointer and operands, latched with start
//   busy            high in every non-idle state
//   done            one-cycle pulse while the high half is written
//   rf_write_en     register-file write port: enable
//   rf_waddr        register-file write port: address
//   rf_data_in      register-file write port: data
module mul_wb_unit #(
    parameter int unsigned  W     = 8,
    parameter int unsigned  D     = 3,
    parameter logic [D-1:0] REG_M = D'(3'b100)
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         start,
    input  logic [D-1:0] dest,
    input  logic [W-1:0] opA,
    input  logic [W-1:0] opB,
    output logic         busy,
    output logic         done,
    output logic         rf_write_en,
    output logic [D-1:0] rf_waddr,
    output logic [W-1:0] rf_data_in
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned CW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MULT  = 2'd1,
        WB_LO = 2'd2,
        WB_HI = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [D-1:0]    dest_q, dest_d;

    logic            busy_d, done_d, we_d;
    logic [D-1:0]    waddr_d;
    logic [W-1:0]    data_d;

    // State, datapath and output registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            dest_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rf_write_en <= 1'b0;
            rf_waddr    <= '0;
            rf_data_in  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            dest_q      <= dest_d;
            busy        <= busy_d;
            done        <= done_d;
            rf_write_en <= we_d;
            rf_waddr    <= waddr_d;
            rf_data_in  <= data_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        dest_d   = dest_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = MULT;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = PW'(opA);
                    mplier_d = opB;
                    dest_d   = dest;
                end
            end
            MULT: begin
                // One multiplier bit per cycle, LSB first. The multiplicand
                // is pre-shifted, so the full-width add keeps every carry.
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = WB_LO;
                end
            end
            WB_LO:   state_d = WB_HI;
            WB_HI:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state and then registered.
    // This keeps them Moore outputs of the current state with no combinational path.
    always_comb begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        we_d    = 1'b0;
        waddr_d = '0;
        data_d  = '0;

        case (state_d)
            MULT: begin
                busy_d = 1'b1;
            end
            WB_LO: begin
                busy_d  = 1'b1;
                we_d    = 1'b1;
                waddr_d = dest_d;
                data_d  = acc_d[W-1:0];
            end
            WB_HI: begin
                busy_d  = 1'b1;
                we_d    = 1'b1;
                done_d  = 1'b1;
                waddr_d = REG_M;
                data_d  = acc_d[PW-1:W];
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

endmodule
